// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the unified-memory port arbiter.
//   arb_state_e : FSM state encoding (IDLE / ACCESS / DONE)
//   SelIf/SelDm : values of the 2:1 address/control mux select
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StAccess = 2'd1,
        StDone   = 2'd2
    } arb_state_e;

    localparam logic SelIf = 1'b0;
    localparam logic SelDm = 1'b1;

endpackage

// File: rtl/mem_port_arbiter_timer.sv
// Access timeout counter for the memory port arbiter.
// Ports:
//   clk     in  clock, rising edge
//   rst     in  synchronous active-high reset
//   clr     in  force count to zero
//   en      in  count one cycle
//   expired out count has reached TIMEOUT-1
module mem_port_arbiter_timer #(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CW      = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    logic [CW-1:0] count_q;

    assign expired = (count_q == CW'(TIMEOUT - 1));

    // Holds at the expiry value so it can never wrap back to zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else if (clr) begin
            count_q <= '0;
        end else if (en && !expired) begin
            count_q <= count_q + 1'b1;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing the single-ported unified memory between instruction fetch
// (IF) and data access (DM). DM has priority; after STARVE_MAX consecutive DM
// grants with IF waiting, IF is forced through. Each access is a
// req -> mem_req ... mem_ready -> ack handshake; a timeout aborts with err.
// Ports:
//   clk, rst  clock and synchronous active-high reset
//   if_req    IF request, held until if_ack
//   dm_req    DM request, held until dm_ack
//   mem_ready memory completes the current access (pulse)
//   mem_req   access in progress
//   sel       mux select, 0 = IF path, 1 = DM path
//   if_ack    IF access complete (pulse)
//   dm_ack    DM access complete (pulse)
//   err       access timed out (pulse, alongside the ack)
//   busy      FSM not idle
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_MAX = 4,
    parameter int unsigned TIMEOUT    = 16,
    parameter int unsigned CW         = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic if_req,
    input  logic dm_req,
    input  logic mem_ready,
    output logic mem_req,
    output logic sel,
    output logic if_ack,
    output logic dm_ack,
    output logic err,
    output logic busy
);

    localparam int unsigned SW = $clog2(STARVE_MAX + 1);

    arb_state_e    state_q, state_d;
    logic [SW-1:0] starve_q, starve_d;
    logic          sel_d, mem_req_d, if_ack_d, dm_ack_d, err_d, busy_d;
    logic          expired;
    logic          grant_dm;

    mem_port_arbiter_timer #(
        .TIMEOUT (TIMEOUT),
        .CW      (CW)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clr     (state_q != StAccess),
        .en      (state_q == StAccess),
        .expired (expired)
    );

    // DM wins unless IF is also waiting and has been passed over too often.
    assign grant_dm = dm_req && !(if_req && (starve_q == SW'(STARVE_MAX)));

    // State register plus registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            starve_q <= '0;
            sel      <= SelIf;
            mem_req  <= 1'b0;
            if_ack   <= 1'b0;
            dm_ack   <= 1'b0;
            err      <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
            sel      <= sel_d;
            mem_req  <= mem_req_d;
            if_ack   <= if_ack_d;
            dm_ack   <= dm_ack_d;
            err      <= err_d;
            busy     <= busy_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (if_req || dm_req) state_d = StAccess;
            StAccess: if (mem_ready || expired) state_d = StDone;
            StDone:   state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // Output / datapath next values; everything is registered above.
    always_comb begin
        sel_d     = sel;
        starve_d  = starve_q;
        mem_req_d = (state_d == StAccess);
        busy_d    = (state_d != StIdle);
        if_ack_d  = 1'b0;
        dm_ack_d  = 1'b0;
        err_d     = 1'b0;

        if (state_q == StIdle && (if_req || dm_req)) begin
            sel_d = grant_dm ? SelDm : SelIf;
            if (grant_dm && if_req) begin
                if (starve_q != SW'(STARVE_MAX)) starve_d = starve_q + 1'b1;
            end else begin
                starve_d = '0;
            end
        end

        if (state_q == StAccess && state_d == StDone) begin
            if_ack_d = (sel == SelIf);
            dm_ack_d = (sel == SelDm);
            // A completion in the expiry cycle counts as success.
            err_d    = !mem_ready;
        end
    end

endmodule
